// File: rtl/gba_ram.sv
// Byte-wide synchronous work RAM on the card bus, write-first, 1-cycle read latency.
// Optional power-up clear sweep: define GBARAM_CLEAR_EN.
module gba_ram #(
    parameter int         ADDR_W     = 16,
    parameter int         DEPTH_LOG2 = 10,
    parameter logic [7:0] FILL       = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] io_card_bus_addr,
    input  logic [7:0]        io_card_bus_mosi,
    output logic [7:0]        io_card_bus_miso,
    input  logic              io_card_bus_write
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  clearing;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_wa;
    logic [7:0]            mem_wd;

    // Upper address bits only select a mirror of the array.
    logic unused_addr;
    assign unused_addr = ^io_card_bus_addr;
    assign idx         = io_card_bus_addr[DEPTH_LOG2-1:0];

`ifdef GBARAM_CLEAR_EN
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + DEPTH_LOG2'(1);
            if (ptr == {DEPTH_LOG2{1'b1}})
                state <= READY;
        end
    end

    assign clearing = (state == CLEAR);

    always_comb begin
        mem_we = io_card_bus_write;
        mem_wa = idx;
        mem_wd = io_card_bus_mosi;
        if (clearing) begin
            mem_we = 1'b1;
            mem_wa = ptr;
            mem_wd = FILL;
        end
    end
`else
    localparam logic [7:0] unused_fill = FILL;

    assign clearing = 1'b0;
    assign mem_we   = io_card_bus_write;
    assign mem_wa   = idx;
    assign mem_wd   = io_card_bus_mosi;
`endif

    // Reset held at an edge discards any write on that edge.
    always_ff @(posedge clock) begin
        if (!reset && mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            io_card_bus_miso <= 8'h00;
        else if (clearing)
            io_card_bus_miso <= 8'h00;
        else if (io_card_bus_write)
            io_card_bus_miso <= io_card_bus_mosi;
        else
            io_card_bus_miso <= mem[idx];
    end

endmodule

// File: tb/tb_gba_ram.sv
// Self-checking bench for gba_ram: vector table with a scoreboard queue,
// plus hand-written reset/mirror/clear-sweep sequences.
module tb_gba_ram;

`ifdef GBARAM_CLEAR_EN
    localparam int DL = 4;
`else
    localparam int DL = 10;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  mosi;
    logic [7:0]  miso;
    logic        write;

    gba_ram #(
        .ADDR_W    (16),
        .DEPTH_LOG2(DL),
        .FILL      (8'h00)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_card_bus_addr (addr),
        .io_card_bus_mosi (mosi),
        .io_card_bus_miso (miso),
        .io_card_bus_write(write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  e;
        bit          chk;
    } vec_t;

    typedef struct {
        logic [7:0] e;
        bit         chk;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic w, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] e,
                       input bit chk, input int n);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.e = e; v.chk = chk;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic drive(input logic w, input logic [15:0] a,
                         input logic [7:0] d);
        @(negedge clock);
        write = w;
        addr  = a;
        mosi  = d;
    endtask

    exp_t       got;
    logic [7:0] prev_e;
    bit         prev_ok;

    initial begin
        reset = 1'b1;
        write = 1'b0;
        addr  = 16'h0000;
        mosi  = 8'h00;

        // Vector table: writes (write-first), idle reads, read-back, mirror
        add(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 2);
        add(1'b1, 16'h0001, 8'h42, 8'h42, 1'b1, 5);
        add(1'b0, 16'h0001, 8'h00, 8'h42, 1'b1, 2);
        add(1'b1, 16'h0002, 8'hAA, 8'hAA, 1'b1, 5);
        add(1'b0, 16'h0002, 8'h00, 8'hAA, 1'b1, 2);
        add(1'b1, 16'h0003, 8'h55, 8'h55, 1'b1, 5);
        add(1'b0, 16'h0003, 8'h00, 8'h55, 1'b1, 2);
        add(1'b0, 16'h0001, 8'h00, 8'h42, 1'b1, 5);
        add(1'b0, 16'h0003, 8'h00, 8'h55, 1'b1, 5);
        add(1'b0, 16'h0002, 8'h00, 8'hAA, 1'b1, 5);
        add(1'b1, 16'h0405, 8'h3C, 8'h3C, 1'b1, 1);
        add(1'b0, 16'h0001, 8'h00, 8'h42, 1'b1, 1);
        add(1'b0, 16'h0005, 8'h00, 8'h3C, 1'b1, 1);
        add(1'b0, 16'hF405, 8'h00, 8'h3C, 1'b1, 1);
        add(1'b0, 16'h0002, 8'h00, 8'hAA, 1'b1, 1);

        repeat (1) @(posedge clock);
        #1 check("reset_miso", miso, 8'h00);
        @(negedge clock);
        reset = 1'b0;

`ifdef GBARAM_CLEAR_EN
        // Sweep: write right after reset is ignored, miso forced low
        for (int i = 0; i < 16; i++) begin
            if (i == 0) drive(1'b1, 16'h0001, 8'h42);
            else        drive(1'b0, 16'h0001, 8'h00);
            @(posedge clock);
            #1 check("clear_miso", miso, 8'h00);
        end
        drive(1'b0, 16'h0001, 8'h00);
        @(posedge clock);
        #1 check("clear_fill", miso, 8'h00);
`endif

        prev_ok = 1'b0;
        prev_e  = 8'h00;
        foreach (vecs[i]) begin
            drive(vecs[i].w, vecs[i].a, vecs[i].d);
            exp_q.push_back('{e: vecs[i].e, chk: vecs[i].chk});
            #1;
            if (prev_ok) check("hold", miso, prev_e);
            @(posedge clock);
            #1;
            got = exp_q.pop_front();
            if (got.chk) check($sformatf("vec%0d", i), miso, got.e);
            prev_ok = got.chk;
            prev_e  = got.e;
        end

        // Asynchronous reset mid-cycle while reading 0x0001
        drive(1'b0, 16'h0001, 8'h00);
        @(posedge clock);
        #1 check("pre_areset", miso, 8'h42);
        #1 reset = 1'b1;
        #1 check("async_reset", miso, 8'h00);
        drive(1'b1, 16'h0001, 8'hEE);
        @(posedge clock);
        #1 check("reset_hold", miso, 8'h00);
        drive(1'b0, 16'h0001, 8'h00);
        reset = 1'b0;
`ifdef GBARAM_CLEAR_EN
        repeat (16) begin
            @(posedge clock);
            #1 check("reclear_miso", miso, 8'h00);
        end
        @(posedge clock);
        #1 check("reclear_fill", miso, 8'h00);
        drive(1'b1, 16'h0001, 8'h42);
        @(posedge clock);
        #1 check("post_clear_wr", miso, 8'h42);
        drive(1'b0, 16'h0001, 8'h00);
        @(posedge clock);
        #1 check("post_clear_rd", miso, 8'h42);
`else
        @(posedge clock);
        #1 check("retained", miso, 8'h42);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
